ws2812_anim: RTL and testbench

Animation sequencer that sits directly upstream of the WS2812 serial driver and feeds its LED write port. Once per frame it computes a colour for every LED (solid, chase, rainbow or off), scales it by a global brightness, and issues one `write` per LED on consecutive cycles. The driver then streams the stored frame to the strip independently.

---
 rtl/ws2812_anim.sv | 232 +++++++++++++++++++++++
 tb/tb_ws2812_anim.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_anim.sv
// ws2812_anim
//
// Animation sequencer feeding the LED write port of a WS2812 serial driver.
// Once per frame it walks every LED index, computes that LED's colour
// (solid, chase, rainbow or off), scales it by a global brightness and
// issues one write per LED on consecutive cycles.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       run the frame prescaler (low holds it at 0)
//   update       single-cycle request to redraw the current phase
//   mode         0 solid, 1 chase, 2 rainbow, 3 off
//   colour       {G,R,B} base colour for solid/chase
//   brightness   global scale factor, out = c*(brightness+1) >> 8
//   rgb_data     {G,R,B} to the driver
//   led_num      LED index to the driver
//   write        driver write strobe
//   busy         a frame is in progress
//   frame_done   one-cycle pulse after the last write of a frame
//   state_dbg    current FSM state (IDLE=0, WRITE=1, DONE=2)
//
// Handshake: write is a push-only strobe with no back-pressure. Each cycle
// write is high, rgb_data/led_num carry one LED update that the driver must
// accept on that edge. Outside writes, rgb_data/led_num hold their last value.
//
// Pipeline: the FSM walks idx; stage 1 registers the unscaled colour and
// index; stage 2 scales and drives the outputs. That two-register path is why
// write appears two edges after the start edge.

module ws2812_anim #(
    parameter int NUM_LEDS    = 8,
    parameter int FRAME_TICKS = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        update,
    input  logic [1:0]  mode,
    input  logic [23:0] colour,
    input  logic [7:0]  brightness,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    localparam int              CW       = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0]   TICK_AT  = CW'(FRAME_TICKS - 1);
    localparam logic [7:0]      LAST_IDX = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          start;
    logic          pending;
    logic [7:0]    idx;
    logic [7:0]    phase;
    logic [7:0]    chase_pos;

    // Per-frame snapshot of the inputs, taken on the start edge.
    logic [1:0]    lat_mode;
    logic [23:0]   lat_colour;
    logic [7:0]    lat_bright;
    logic          lat_timed;

    // Stage 1 registers.
    logic          s1_write;
    logic          s1_done;
    logic [7:0]    s1_idx;
    logic [23:0]   s1_col;

    // Unscaled colour of the current idx.
    logic [23:0]   col_raw;
    logic [7:0]    hue, hue_t, up, down;

    assign tick      = enable && (cnt == TICK_AT);
    assign start     = (state == IDLE) && (tick || update || pending);
    assign state_dbg = state;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [8:0]  b1;
        logic [16:0] p;
        b1 = {1'b0, b} + 9'd1;
        p  = {9'd0, c} * {8'd0, b1};
        return p[15:8];
    endfunction

    // Prescaler
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame bookkeeping: snapshot, index walk, phase/chase advance, pending redraw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            phase      <= '0;
            chase_pos  <= '0;
            pending    <= 1'b0;
            lat_mode   <= '0;
            lat_colour <= '0;
            lat_bright <= '0;
            lat_timed  <= 1'b0;
        end else begin
            if (start) begin
                pending <= 1'b0;
            end else if (update && state != IDLE) begin
                pending <= 1'b1;
            end

            if (start) begin
                idx        <= '0;
                lat_mode   <= mode;
                lat_colour <= colour;
                lat_bright <= brightness;
                // A tick together with update counts as a timed frame.
                lat_timed  <= tick;
            end else if (state == WRITE) begin
                idx <= idx + 8'd1;
            end

            // Only timed frames move the animation forward.
            if (state == DONE && lat_timed) begin
                phase     <= phase + 8'd1;
                chase_pos <= (chase_pos == LAST_IDX) ? 8'd0 : chase_pos + 8'd1;
            end
        end
    end

    // Colour generator. Rainbow hue steps 32 per LED, so only idx[2:0] matters.
    always_comb begin
        hue     = phase + {idx[2:0], 5'b0};
        hue_t   = hue;
        col_raw = '0;
        if (hue >= 8'd170) begin
            hue_t = hue - 8'd170;
        end else if (hue >= 8'd85) begin
            hue_t = hue - 8'd85;
        end
        // 3*hue_t never exceeds 255, so 8-bit arithmetic is exact.
        up   = hue_t + {hue_t[6:0], 1'b0};
        down = 8'd255 - up;
        case (lat_mode)
            2'd0: col_raw = lat_colour;
            2'd1: if (idx == chase_pos) col_raw = lat_colour;
            2'd2: begin
                if (hue < 8'd85) begin
                    col_raw = {up, down, 8'd0};
                end else if (hue < 8'd170) begin
                    col_raw = {down, 8'd0, up};
                end else begin
                    col_raw = {8'd0, up, down};
                end
            end
            default: col_raw = '0;
        endcase
    end

    // Stage 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_write <= 1'b0;
            s1_done  <= 1'b0;
            s1_idx   <= '0;
            s1_col   <= '0;
        end else begin
            s1_write <= (state == WRITE);
            s1_done  <= (state == DONE);
            if (state == WRITE) begin
                s1_idx <= idx;
                s1_col <= col_raw;
            end
        end
    end

    // Stage 2: scaled outputs. busy also covers the frame_done cycle, when the
    // FSM itself is already back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_data   <= '0;
            led_num    <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            write      <= s1_write;
            frame_done <= s1_done;
            busy       <= (state != IDLE) || s1_done;
            if (s1_write) begin
                led_num  <= s1_idx;
                rgb_data <= {scale(s1_col[23:16], lat_bright),
                             scale(s1_col[15:8],  lat_bright),
                             scale(s1_col[7:0],   lat_bright)};
            end
        end
    end

endmodule

// File: tb/tb_ws2812_anim.sv
module tb_ws2812_anim;

  localparam int NL = 8;
  localparam int FT = 20;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        update = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] colour = 24'd0;
  logic [7:0]  brightness = 8'd0;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        busy;
  logic        frame_done;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_anim #(.NUM_LEDS(NL), .FRAME_TICKS(FT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .update     (update),
    .mode       (mode),
    .colour     (colour),
    .brightness (brightness),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // scoreboard state
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];         // {led_num, rgb_data}
  int          done_times[$];
  int          done_cnt = 0;
  int          write_cnt = 0;
  int          last_write_cyc = -100;
  logic [7:0]  last_led = 8'd0;
  logic [31:0] mon_exp;

  // Rainbow frame at phase 0, hand-computed: h = 0,32,...,224
  logic [23:0] rb_tab [8] = '{24'h00FF00, 24'h609F00, 24'hC03F00, 24'hDE0021,
                              24'h7E0081, 24'h1E00E1, 24'h0042BD, 24'h00A25D};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: led %0d rgb %h, want no write", led_num, rgb_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_data", {led_num, rgb_data}, mon_exp);
      end
      if (led_num != 8'd0) check("write_consecutive", cyc - last_write_cyc, 1);
      last_write_cyc = cyc;
      last_led = led_num;
      write_cnt++;
    end
    if (frame_done === 1'b1) begin
      check("done_after_last_write", cyc - last_write_cyc, 1);
      check("done_last_led", {24'd0, last_led}, NL - 1);
      done_cnt++;
      done_times.push_back(cyc);
    end
  end

  // driver tasks
  task automatic push_solid(input logic [23:0] c);
    for (int i = 0; i < NL; i++) exp_q.push_back({8'(i), c});
  endtask

  task automatic push_rainbow0();
    for (int i = 0; i < NL; i++) exp_q.push_back({8'(i), rb_tab[i]});
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_done_in_budget", (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic redraw_frame();
    int d;
    d = done_cnt;
    pulse_update();
    wait_done(d + 1, 40);
  endtask

  initial begin
    int d;
    int dt0;
    int k;
    int wc;

    // reset values
    repeat (3) @(negedge clk);
    check("reset_rgb", {8'd0, rgb_data}, 0);
    check("reset_led", {24'd0, led_num}, 0);
    check("reset_write", {31'd0, write}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, frame_done}, 0);
    check("reset_state", {30'd0, state_dbg}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // solid redraw with latency checks
    mode = 2'd0; colour = 24'h102030; brightness = 8'd255;
    push_solid(24'h102030);
    d = done_cnt;
    pulse_update();                       // now just after edge n
    check("busy_at_n", {31'd0, busy}, 0);
    check("write_at_n", {31'd0, write}, 0);
    @(negedge clk);                       // after edge n+1
    check("busy_at_n1", {31'd0, busy}, 1);
    check("write_at_n1", {31'd0, write}, 0);
    @(negedge clk);                       // after edge n+2
    check("write_at_n2", {31'd0, write}, 1);
    wait_done(d + 1, 40);
    check("busy_idle", {31'd0, busy}, 0);
    check("write_idle", {31'd0, write}, 0);

    // brightness scaling
    colour = 24'hFF8001; brightness = 8'd127;
    push_solid(24'h7F4000);
    redraw_frame();
    brightness = 8'd0;
    push_solid(24'h000000);
    redraw_frame();

    // rainbow at phase 0 (redraws above must not have moved phase)
    mode = 2'd2; brightness = 8'd255;
    push_rainbow0();
    redraw_frame();

    // pending redraw and mid-frame colour change
    mode = 2'd0; colour = 24'h0A0B0C;
    push_solid(24'h0A0B0C);
    push_solid(24'h00FF00);
    d = done_cnt;
    pulse_update();
    repeat (2) @(negedge clk);
    colour = 24'h00FF00;
    pulse_update();
    k = 0;
    while (frame_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (write !== 1'b1 && k < 20);
    check("pending_restart_gap", k, 2);
    wait_done(d + 2, 60);

    // chase, 10 timed frames
    mode = 2'd1; colour = 24'h0000FF;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < NL; i++)
        exp_q.push_back({8'(i), (i == f % NL) ? 24'h0000FF : 24'h000000});
    d = done_cnt;
    dt0 = done_times.size();
    enable = 1'b1;
    wait_done(d + 10, 10 * FT + 60);
    enable = 1'b0;
    if (done_times.size() >= dt0 + 10)
      for (int j = 1; j < 10; j++)
        check("frame_spacing", done_times[dt0 + j] - done_times[dt0 + j - 1], FT);

    // reset mid-frame at the 4th write
    mode = 2'd0; colour = 24'h123456;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 24'h123456});
    pulse_update();
    k = 0;
    while (!(write === 1'b1 && led_num == 8'd3) && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1 reset = 1'b0;
    #1;
    check("abort_write", {31'd0, write}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rgb", {8'd0, rgb_data}, 0);
    check("abort_led", {24'd0, led_num}, 0);
    check("abort_state", {30'd0, state_dbg}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wc = write_cnt;
    repeat (40) @(negedge clk);
    check("no_write_after_reset", write_cnt - wc, 0);
    check("queue_drained_after_abort", exp_q.size(), 0);

    // rainbow right after reset: phase back to 0
    mode = 2'd2;
    push_rainbow0();
    redraw_frame();

    // 256 timed frames in off mode wrap phase back to 0
    mode = 2'd3; colour = 24'hFFFFFF;
    for (int i = 0; i < 256 * NL; i++) exp_q.push_back({8'(i % NL), 24'h000000});
    d = done_cnt;
    enable = 1'b1;
    wait_done(d + 256, 256 * FT + 100);
    enable = 1'b0;
    mode = 2'd2;
    push_rainbow0();
    redraw_frame();

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
